seg_digit_scanner: RTL and testbench

//  Time-multiplexed digit scanner for multi-digit 7-segment displays: drives one-cold,

---
 rtl/seg_digit_scanner.sv | 140 ++++++++++++++
 tb/tb_seg_digit_scanner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner: time-multiplexed digit scanner for multi-digit 7-segment
// displays. Lights one digit at a time through one-cold active-low enables,
// presents that digit's nibble to the segment encoder, and inserts an
// all-dark gap between digits to suppress ghosting. Masked-off digits are
// skipped entirely.

module seg_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SEL_W        = $clog2(NUM_DIGITS),
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [4*NUM_DIGITS-1:0] data,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [SEL_W-1:0]        digit_idx,
  output logic [3:0]              nibble,
  output logic                    scan_tick,
  output logic                    frame_done
);

  // One counter serves both the lit period and the blank gap.
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [SEL_W-1:0] first_idx;
  logic [SEL_W-1:0] next_idx;
  logic             active;

  assign active = en && (digit_en != '0);

  // Lowest enabled digit, used when scanning starts from IDLE.
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand      = '0;
    first_idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      cand = SEL_W'(i);
      if (digit_en[cand]) first_idx = cand;
    end
  end

  // Next enabled digit after the current one, wrapping; falls back to itself.
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand     = '0;
    next_idx = digit_idx;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      cand = SEL_W'((int'(digit_idx) + k) % NUM_DIGITS);
      if (digit_en[cand]) next_idx = cand;
    end
  end

  // Scan FSM: all outputs are registered and change together on digit entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      an_n       <= '1;
      digit_idx  <= '0;
      nibble     <= '0;
      scan_tick  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      scan_tick  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          an_n    <= '1;
          counter <= '0;
          if (active) begin
            state     <= SHOW;
            digit_idx <= first_idx;
            nibble    <= data[{first_idx, 2'b00} +: 4];
            an_n      <= ~(NUM_DIGITS'(1) << first_idx);
            scan_tick <= 1'b1;
          end
        end
        SHOW: begin
          if (!active) begin
            state   <= IDLE;
            an_n    <= '1;
            counter <= '0;
          end else if (counter == SHOW_LAST) begin
            counter <= '0;
            if (BLANK_CYCLES > 0) begin
              state <= BLANK;
              an_n  <= '1;
            end else begin
              digit_idx  <= next_idx;
              nibble     <= data[{next_idx, 2'b00} +: 4];
              an_n       <= ~(NUM_DIGITS'(1) << next_idx);
              scan_tick  <= 1'b1;
              frame_done <= (next_idx <= digit_idx);
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end
        BLANK: begin
          if (!active) begin
            state   <= IDLE;
            an_n    <= '1;
            counter <= '0;
          end else if (counter == BLANK_LAST) begin
            state      <= SHOW;
            counter    <= '0;
            digit_idx  <= next_idx;
            nibble     <= data[{next_idx, 2'b00} +: 4];
            an_n       <= ~(NUM_DIGITS'(1) << next_idx);
            scan_tick  <= 1'b1;
            frame_done <= (next_idx <= digit_idx);
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          an_n  <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed testbench for seg_digit_scanner. The main instance uses
// NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1; a second instance with
// PRESCALE=1, BLANK_CYCLES=0 covers gapless rotation.

module tb_seg_digit_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  digit_en;
  logic [15:0] data;

  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic [3:0]  nibble;
  logic        scan_tick;
  logic        frame_done;

  logic [3:0]  an_n_nb;
  logic [1:0]  digit_idx_nb;
  logic [3:0]  nibble_nb;
  logic        scan_tick_nb;
  logic        frame_done_nb;

  int tests_run    = 0;
  int tests_failed = 0;

  seg_digit_scanner #(
    .NUM_DIGITS(4), .SEL_W(2), .PRESCALE(4), .BLANK_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_en(digit_en), .data(data),
    .an_n(an_n), .digit_idx(digit_idx), .nibble(nibble),
    .scan_tick(scan_tick), .frame_done(frame_done)
  );

  seg_digit_scanner #(
    .NUM_DIGITS(4), .SEL_W(2), .PRESCALE(1), .BLANK_CYCLES(0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_en(digit_en), .data(data),
    .an_n(an_n_nb), .digit_idx(digit_idx_nb), .nibble(nibble_nb),
    .scan_tick(scan_tick_nb), .frame_done(frame_done_nb)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Packed view: {an_n, digit_idx, nibble, scan_tick, frame_done}.
  task automatic test_reset;
    logic [11:0] got;
    rst_n = 1'b0; en = 1'b0; digit_en = 4'h0; data = 16'h0;
    tick; tick;
    got = {an_n, digit_idx, nibble, scan_tick, frame_done};
    tests_run++;
    if (got !== {4'b1111, 2'd0, 4'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_initial got=%b expected=%b", got, {4'b1111, 2'd0, 4'd0, 2'b00});
    end
    rst_n = 1'b1; en = 1'b1; digit_en = 4'hF; data = 16'h4321;
    for (int i = 0; i < 12; i++) tick;
    got = {an_n, digit_idx, nibble, scan_tick, frame_done};
    tests_run++;
    if (got !== {4'b1011, 2'd2, 4'd3, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_pre_show got=%b expected=%b", got, {4'b1011, 2'd2, 4'd3, 2'b00});
    end
    rst_n = 1'b0;
    tick;
    got = {an_n, digit_idx, nibble, scan_tick, frame_done};
    tests_run++;
    if (got !== {4'b1111, 2'd0, 4'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_show got=%b expected=%b", got, {4'b1111, 2'd0, 4'd0, 2'b00});
    end
    rst_n = 1'b1; en = 1'b0;
    tick;
  endtask

  task automatic test_scan;
    logic [11:0] got, exp;
    int p;
    en = 1'b0; tick;
    digit_en = 4'hF; data = 16'h4321; en = 1'b1;
    for (int cyc = 0; cyc < 41; cyc++) begin
      tick;
      p = cyc % 20;
      exp[11:8] = (p % 5 == 4) ? 4'b1111 : ~(4'b0001 << (p / 5));
      exp[7:6]  = 2'(p / 5);
      exp[5:2]  = 4'(p / 5 + 1);
      exp[1]    = (p % 5 == 0);
      exp[0]    = (p == 0) && (cyc > 0);
      got = {an_n, digit_idx, nibble, scan_tick, frame_done};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL scan_full cyc=%0d got=%b expected=%b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_sparse;
    logic [11:0] got, exp;
    int p;
    en = 1'b0; tick;
    digit_en = 4'b1010; data = 16'h4321; en = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick;
      p = cyc % 10;
      exp[11:8] = (p % 5 == 4) ? 4'b1111 : ((p < 5) ? 4'b1101 : 4'b0111);
      exp[7:6]  = (p < 5) ? 2'd1 : 2'd3;
      exp[5:2]  = (p < 5) ? 4'd2 : 4'd4;
      exp[1]    = (p % 5 == 0);
      exp[0]    = (p == 0) && (cyc > 0);
      got = {an_n, digit_idx, nibble, scan_tick, frame_done};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL scan_sparse cyc=%0d got=%b expected=%b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_single;
    logic [11:0] got, exp;
    int p;
    en = 1'b0; tick;
    digit_en = 4'b0100; data = 16'h4321; en = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick;
      p = cyc % 5;
      exp[11:8] = (p == 4) ? 4'b1111 : 4'b1011;
      exp[7:6]  = 2'd2;
      exp[5:2]  = 4'd3;
      exp[1]    = (p == 0);
      exp[0]    = (p == 0) && (cyc > 0);
      got = {an_n, digit_idx, nibble, scan_tick, frame_done};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL scan_single cyc=%0d got=%b expected=%b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_en_drop;
    logic [11:0] got;
    en = 1'b0; tick;
    digit_en = 4'b1100; data = 16'h4321; en = 1'b1;
    tick;
    got = {an_n, digit_idx, nibble, scan_tick, frame_done};
    tests_run++;
    if (got !== {4'b1011, 2'd2, 4'd3, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL en_drop_start got=%b expected=%b", got, {4'b1011, 2'd2, 4'd3, 2'b10});
    end
    tick; tick;
    en = 1'b0;
    tick;
    got = {an_n, digit_idx, nibble, scan_tick, frame_done};
    tests_run++;
    if (got !== {4'b1111, 2'd2, 4'd3, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL en_drop_dark got=%b expected=%b", got, {4'b1111, 2'd2, 4'd3, 2'b00});
    end
    tick;
    got = {an_n, digit_idx, nibble, scan_tick, frame_done};
    tests_run++;
    if (got !== {4'b1111, 2'd2, 4'd3, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL en_drop_idle got=%b expected=%b", got, {4'b1111, 2'd2, 4'd3, 2'b00});
    end
    digit_en = 4'b1110; en = 1'b1;
    tick;
    got = {an_n, digit_idx, nibble, scan_tick, frame_done};
    tests_run++;
    if (got !== {4'b1101, 2'd1, 4'd2, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL en_restart got=%b expected=%b", got, {4'b1101, 2'd1, 4'd2, 2'b10});
    end
  endtask

  task automatic test_data_latch;
    logic [11:0] got;
    en = 1'b0; tick;
    digit_en = 4'hF; data = 16'h4321; en = 1'b1;
    tick; tick;
    data = 16'h8765;
    tick;
    got = {an_n, digit_idx, nibble, scan_tick, frame_done};
    tests_run++;
    if (got !== {4'b1110, 2'd0, 4'd1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL latch_hold got=%b expected=%b", got, {4'b1110, 2'd0, 4'd1, 2'b00});
    end
    tick; tick;
    got = {an_n, digit_idx, nibble, scan_tick, frame_done};
    tests_run++;
    if (got !== {4'b1111, 2'd0, 4'd1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL latch_blank got=%b expected=%b", got, {4'b1111, 2'd0, 4'd1, 2'b00});
    end
    tick;
    got = {an_n, digit_idx, nibble, scan_tick, frame_done};
    tests_run++;
    if (got !== {4'b1101, 2'd1, 4'd6, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL latch_update got=%b expected=%b", got, {4'b1101, 2'd1, 4'd6, 2'b10});
    end
  endtask

  task automatic test_no_blank;
    logic [11:0] got, exp;
    int p;
    en = 1'b0; tick;
    digit_en = 4'hF; data = 16'h4321; en = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick;
      p = cyc % 4;
      exp[11:8] = ~(4'b0001 << p);
      exp[7:6]  = 2'(p);
      exp[5:2]  = 4'(p + 1);
      exp[1]    = 1'b1;
      exp[0]    = (p == 0) && (cyc > 0);
      got = {an_n_nb, digit_idx_nb, nibble_nb, scan_tick_nb, frame_done_nb};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL no_blank cyc=%0d got=%b expected=%b", cyc, got, exp);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset;
    test_scan;
    test_sparse;
    test_single;
    test_en_drop;
    test_data_latch;
    test_no_blank;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
